// File: rtl/ccl_pkg.sv
// ccl_pkg: shared defaults and sizing helpers for the CCL row packer.
// CCL_BITREV_EN (see ccl_cell_map) selects the legacy MSB-first cell map.
package ccl_pkg;

    localparam int CCL_CELL_W = 3;
    localparam int CCL_CELLS  = 10;
    localparam int CCL_SKIP   = 2;

    function automatic int ccl_bytes(input int skip, input int row_w);
        return (skip + row_w + 7) / 8;
    endfunction

    function automatic int ccl_idx_w(input int bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

endpackage

// File: rtl/ccl_row_packer_if.sv
// ccl_row_packer_if: byte stream in, packed row out, plus flush and status.
// CCL_BITREV_EN has no effect here; it only changes the cell map.
interface ccl_row_packer_if
    import ccl_pkg::*;
#(
    parameter int ROW_W = CCL_CELL_W * CCL_CELLS,
    parameter int SKIP  = CCL_SKIP
);
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic             in_sof;
    logic [7:0]       in_byte;
    logic             row_valid;
    logic             row_ready;
    logic [ROW_W-1:0] row_data;
    logic [SKIP-1:0]  row_tag;
    logic             sync_err;
    logic [15:0]      row_cnt;

    modport slave (
        input  clr, in_valid, in_sof, in_byte, row_ready,
        output in_ready, row_valid, row_data, row_tag, sync_err, row_cnt
    );

    modport master (
        output clr, in_valid, in_sof, in_byte, row_ready,
        input  in_ready, row_valid, row_data, row_tag, sync_err, row_cnt
    );
endinterface

// File: rtl/ccl_cell_map.sv
// ccl_cell_map: combinational stream-to-row/tag bit mapping.
// CCL_BITREV_EN defined: each cell is read MSB-first (legacy map format).
module ccl_cell_map #(
    parameter int CELL_W = 3,
    parameter int CELLS  = 10,
    parameter int SKIP   = 2,
    parameter int BYTES  = 4
) (
    input  logic [8*BYTES-1:0]      stream,
    output logic [CELL_W*CELLS-1:0] row,
    output logic [SKIP-1:0]         tag
);
    always_comb begin
        row = '0;
        tag = stream[SKIP-1:0];
        for (int i = 0; i < CELLS; i++) begin
            for (int j = 0; j < CELL_W; j++) begin
`ifdef CCL_BITREV_EN
                row[CELL_W*i+j] = stream[SKIP+CELL_W*i+CELL_W-1-j];
`else
                row[CELL_W*i+j] = stream[SKIP+CELL_W*i+j];
`endif
            end
        end
    end
endmodule

// File: rtl/ccl_row_packer.sv
// ccl_row_packer: double-buffered byte-to-row packer (needs BYTES >= 2).
// CCL_BITREV_EN selects the legacy MSB-first cell order in ccl_cell_map.
module ccl_row_packer
    import ccl_pkg::*;
#(
    parameter int CELL_W = CCL_CELL_W,
    parameter int CELLS  = CCL_CELLS,
    parameter int SKIP   = CCL_SKIP
) (
    input  logic             clk,
    input  logic             rst,
    ccl_row_packer_if.slave  bus
);
    localparam int ROW_W = CELL_W * CELLS;
    localparam int BYTES = ccl_bytes(SKIP, ROW_W);
    localparam int IW    = ccl_idx_w(BYTES);
    localparam int AW    = 8 * (BYTES - 1);

    logic [IW-1:0]    idx_q, idx_n;
    logic [AW-1:0]    asm_q, asm_n;
    logic             vld_q, vld_n;
    logic [ROW_W-1:0] data_q;
    logic [SKIP-1:0]  tag_q;
    logic             serr_q;
    logic [15:0]      cnt_q, cnt_n;

    logic [ROW_W-1:0] map_row;
    logic [SKIP-1:0]  map_tag;
    logic             last, acc, resync, done;

    ccl_cell_map #(
        .CELL_W (CELL_W),
        .CELLS  (CELLS),
        .SKIP   (SKIP),
        .BYTES  (BYTES)
    ) u_map (
        .stream ({bus.in_byte, asm_q}),
        .row    (map_row),
        .tag    (map_tag)
    );

    // Only the completing byte waits for the held row to drain.
    assign last   = (idx_q == IW'(BYTES - 1));
    assign bus.in_ready = !rst && !(last && vld_q && !bus.row_ready);
    assign acc    = bus.in_valid && bus.in_ready && !bus.clr;
    assign resync = acc && bus.in_sof && (idx_q != '0);
    assign done   = acc && !resync && last;

    always_comb begin
        idx_n = idx_q;
        asm_n = asm_q;
        vld_n = vld_q;
        cnt_n = cnt_q;
        if (bus.clr) begin
            idx_n = '0;
            asm_n = '0;
            vld_n = 1'b0;
        end else begin
            if (vld_q && bus.row_ready)
                vld_n = 1'b0;
            if (resync) begin
                asm_n      = '0;
                asm_n[7:0] = bus.in_byte;
                idx_n      = IW'(1);
            end else if (done) begin
                asm_n = '0;
                idx_n = '0;
                vld_n = 1'b1;
                cnt_n = cnt_q + 16'd1;
            end else if (acc) begin
                for (int k = 0; k < BYTES - 1; k++)
                    if (idx_q == IW'(k))
                        asm_n[8*k +: 8] = bus.in_byte;
                idx_n = idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            asm_q  <= '0;
            vld_q  <= 1'b0;
            data_q <= '0;
            tag_q  <= '0;
            serr_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            idx_q  <= idx_n;
            asm_q  <= asm_n;
            vld_q  <= vld_n;
            serr_q <= resync;
            cnt_q  <= cnt_n;
            if (done) begin
                data_q <= map_row;
                tag_q  <= map_tag;
            end
        end
    end

    assign bus.row_valid = vld_q;
    assign bus.row_data  = data_q;
    assign bus.row_tag   = tag_q;
    assign bus.sync_err  = serr_q;
    assign bus.row_cnt   = cnt_q;
endmodule
